// File: rtl/meta_package.sv
// Shared queue-manager types: the descriptor payload carried through the queues
// and the default entry-pointer width.
package meta_package;

    localparam int PU_QUEUE_ENTRIES_NBITS = 8;

    typedef struct packed {
        logic [15:0] buf_addr;
        logic [11:0] len;
        logic [3:0]  flags;
    } pu_queue_payload_type;

endpackage

// File: rtl/piarb_qm_deq.sv
// Queue-manager dequeue engine: pops the head entry of a linked-list queue held in
// external 1-cycle-latency memories and returns its descriptor and the freed entry.
`ifndef PU_QUEUE_ENTRIES_NBITS
`define PU_QUEUE_ENTRIES_NBITS meta_package::PU_QUEUE_ENTRIES_NBITS
`endif

module piarb_qm_deq
    import meta_package::*;
#(
    parameter int QUEUE_ID_NBITS      = 5,
    parameter int QUEUE_ENTRIES_NBITS = `PU_QUEUE_ENTRIES_NBITS
) (
    input  logic                           clk,
    input  logic                           rst,
    // Request handshake: a dequeue is taken on a rising clk edge where deq_req and
    // deq_ready are both 1; deq_ready is high only while idle. Results are one-cycle
    // deq_valid pulses, with deq_empty set when the queue held nothing.
    input  logic                           deq_req,
    input  logic [QUEUE_ID_NBITS-1:0]      deq_qid,
    output logic                           deq_ready,
    output logic                           deq_valid,
    output logic                           deq_empty,
    output pu_queue_payload_type           deq_desc,
    output logic [QUEUE_ID_NBITS-1:0]      head_raddr,
    output logic [QUEUE_ID_NBITS-1:0]      depth_raddr,
    input  logic [QUEUE_ENTRIES_NBITS-1:0] head_rdata,
    input  logic [QUEUE_ENTRIES_NBITS-1:0] depth_rdata,
    output logic                           head_wr,
    output logic                           depth_wr,
    output logic [QUEUE_ID_NBITS-1:0]      head_waddr,
    output logic [QUEUE_ID_NBITS-1:0]      depth_waddr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] head_wdata,
    output logic [QUEUE_ENTRIES_NBITS-1:0] depth_wdata,
    output logic [QUEUE_ENTRIES_NBITS-1:0] ll_raddr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] desc_raddr,
    input  logic [QUEUE_ENTRIES_NBITS-1:0] ll_rdata,
    input  pu_queue_payload_type           desc_rdata,
    output logic                           free_valid,
    output logic [QUEUE_ENTRIES_NBITS-1:0] free_ptr,
    output logic [31:0]                    deq_count,
    output logic [1:0]                     dbg_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_HEAD   = 2'd1,
        RD_LINK   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    state_t                         state;
    state_t                         state_nx;
    logic [QUEUE_ID_NBITS-1:0]      qid_r;
    logic [QUEUE_ENTRIES_NBITS-1:0] head_r;
    logic [QUEUE_ENTRIES_NBITS-1:0] depth_r;
    pu_queue_payload_type           desc_r;
    logic [31:0]                    deq_count_r;
    logic                           accept;
    logic                           depth_zero;

    assign accept     = (state == IDLE) && deq_req;
    assign depth_zero = (depth_rdata == '0);
    assign deq_count  = deq_count_r;
    assign dbg_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (deq_req) state_nx = RD_HEAD;
            RD_HEAD:   state_nx = RD_LINK;
            RD_LINK:   state_nx = depth_zero ? IDLE : WRITEBACK;
            WRITEBACK: state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Head and depth are captured in RD_LINK because the memories may change
    // their read data once the address moves away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qid_r       <= '0;
            head_r      <= '0;
            depth_r     <= '0;
            desc_r      <= '0;
            deq_count_r <= '0;
        end else begin
            if (accept) begin
                qid_r <= deq_qid;
            end
            if ((state == RD_LINK) && !depth_zero) begin
                head_r  <= head_rdata;
                depth_r <= depth_rdata;
            end
            if (state == WRITEBACK) begin
                desc_r      <= desc_rdata;
                deq_count_r <= deq_count_r + 32'd1;
            end
        end
    end

    // The result descriptor is live from memory during WRITEBACK and held after.
    assign deq_desc = (state == WRITEBACK) ? desc_rdata : desc_r;

    always_comb begin
        deq_ready   = 1'b0;
        deq_valid   = 1'b0;
        deq_empty   = 1'b0;
        head_raddr  = '0;
        depth_raddr = '0;
        head_wr     = 1'b0;
        depth_wr    = 1'b0;
        head_waddr  = '0;
        depth_waddr = '0;
        head_wdata  = '0;
        depth_wdata = '0;
        ll_raddr    = '0;
        desc_raddr  = '0;
        free_valid  = 1'b0;
        free_ptr    = '0;
        case (state)
            IDLE: begin
                deq_ready = 1'b1;
            end
            RD_HEAD: begin
                head_raddr  = qid_r;
                depth_raddr = qid_r;
            end
            RD_LINK: begin
                if (depth_zero) begin
                    deq_valid = 1'b1;
                    deq_empty = 1'b1;
                end else begin
                    ll_raddr   = head_rdata;
                    desc_raddr = head_rdata;
                end
            end
            WRITEBACK: begin
                head_wr     = 1'b1;
                head_waddr  = qid_r;
                head_wdata  = ll_rdata;
                depth_wr    = 1'b1;
                depth_waddr = qid_r;
                depth_wdata = depth_r - QUEUE_ENTRIES_NBITS'(1);
                deq_valid   = 1'b1;
                free_valid  = 1'b1;
                free_ptr    = head_r;
            end
            default: begin
                deq_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/piarb_qm_deq.md
PIARB_QM_DEQ -- requirements
Module: piarb_qm_deq

Interface
REQ-001 SHALL have parameter QUEUE_ID_NBITS, default 5, width of the queue id.
REQ-002 SHALL have parameter QUEUE_ENTRIES_NBITS, default `PU_QUEUE_ENTRIES_NBITS, width of an entry pointer and of a depth count.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports deq_req (input, 1) and deq_qid (input, QUEUE_ID_NBITS) to request a dequeue; deq_ready (output, 1) accepts it.
REQ-006 SHALL have ports deq_valid (output, 1), deq_empty (output, 1) and deq_desc (output, pu_queue_payload_type) to return the result.
REQ-007 SHALL have ports head_raddr, depth_raddr (output, QUEUE_ID_NBITS) and head_rdata, depth_rdata (input, QUEUE_ENTRIES_NBITS).
REQ-008 SHALL have ports head_wr, depth_wr (output, 1), head_waddr, depth_waddr (output, QUEUE_ID_NBITS) and head_wdata, depth_wdata (output, QUEUE_ENTRIES_NBITS).
REQ-009 SHALL have ports ll_raddr, desc_raddr (output, QUEUE_ENTRIES_NBITS), ll_rdata (input, QUEUE_ENTRIES_NBITS) and desc_rdata (input, pu_queue_payload_type).
REQ-010 SHALL have ports free_valid (output, 1) and free_ptr (output, QUEUE_ENTRIES_NBITS) to return the freed entry to the free list.
REQ-011 SHALL have port deq_count (output, 32), the count of successful dequeues.

Function
REQ-012 SHALL treat every memory as 1-cycle read latency: rdata is valid the cycle after raddr.
REQ-013 SHALL implement states IDLE, RD_HEAD, RD_LINK and WRITEBACK.
REQ-014 SHALL drive deq_ready=1 only in IDLE; deq_req&deq_ready at cycle T latches deq_qid into qid_r and moves to RD_HEAD.
REQ-015 SHALL drive head_raddr=depth_raddr=qid_r in RD_HEAD (T+1); next state RD_LINK.
REQ-016 SHALL, in RD_LINK (T+2) with depth_rdata==0, pulse deq_valid=1 and deq_empty=1, issue no write, and return to IDLE.
REQ-017 SHALL, in RD_LINK with depth_rdata!=0, register head_rdata and depth_rdata, drive ll_raddr=desc_raddr=head_rdata, and go to WRITEBACK.
REQ-018 SHALL, in WRITEBACK (T+3), pulse head_wr (head_wdata=ll_rdata), depth_wr (depth_wdata=depth-1), both at qid_r.
REQ-019 SHALL, in WRITEBACK, also pulse deq_valid=1 with deq_empty=0, deq_desc=desc_rdata, free_valid=1 and free_ptr=registered head; then return to IDLE.
REQ-020 SHALL hold deq_desc between results; deq_empty and all write/valid strobes are single-cycle pulses.
REQ-021 SHALL give a non-empty dequeue latency of 3 cycles (accept to deq_valid), an empty one 2 cycles, and a next accept no earlier than T+4 / T+3.
REQ-022 SHALL never decrement depth below 0; depth==1 writes depth 0 and head=ll_rdata (stale, overwritten by the enqueue side).
REQ-023 SHALL increment deq_count, wrapping at 2^32, on each non-empty WRITEBACK.
REQ-024 SHALL ignore deq_qid and deq_req outside IDLE.

Reset
REQ-025 SHALL, on rst at any time, force state IDLE, deq_valid, deq_empty, free_valid, head_wr and depth_wr to 0, deq_desc to 0, deq_count to 0, and all address/data outputs to 0.
REQ-026 SHALL, on reset mid-operation, issue no pending write, leaving memory contents unchanged.

Structure
REQ-027 SHALL take pu_queue_payload_type from meta_package; the state enum stays local.
REQ-028 SHALL be a single module with no sub-modules; the memories are external and connect to the queue-manager datapath.

Verification
REQ-029 SHALL check empty dequeue: qid 3, depth[3]=0 -> deq_valid and deq_empty at T+2, no writes, deq_count unchanged.
REQ-030 SHALL check single dequeue: qid 5, head=0x12, depth=2, ll[0x12]=0x34 -> at T+3 head[5]=0x34, depth[5]=1, desc=desc[0x12], free_ptr=0x12.
REQ-031 SHALL check a drain to empty: three dequeues on qid 0, depth 3 -> depths 2,1,0, then a fourth returns deq_empty.
REQ-032 SHALL check back-to-back requests: deq_req held high -> accepts spaced exactly 4 cycles; deq_qid changes mid-operation are ignored.
REQ-033 SHALL check reset in WRITEBACK-1 (RD_LINK): rst asserted -> no head_wr/depth_wr, deq_count 0, deq_ready=1 after release.
REQ-034 SHALL check deq_count wrap: preload 0xFFFF_FFFF via force, one dequeue -> 0.
